// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch bus between ifetch_unit and imem.
// The fetch unit drives the request side; memory returns the word.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: PC register, next-PC select and imem handshake.
// Halts with sticky flags on misaligned targets or fetch timeout.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          npc_op,
    input  logic                zero,
    input  logic [15:0]         imm16,
    input  logic [25:0]         target26,
    input  logic [31:0]         jr_addr,
    input  logic                advance,
    ifetch_unit_if.master       imem,
    output logic [31:0]         instr,
    output logic [5:0]          op,
    output logic [5:0]          func,
    output logic                instr_valid,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic                misalign_err,
    output logic                bus_err
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    logic          req_q, req_d;
    logic          valid_q, valid_d;
    logic          merr_q, merr_d;
    logic          berr_q, berr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] p4;
    logic [31:0] boff;
    logic [31:0] jmp;
    logic [31:0] npc;

    assign p4   = pc_q + 32'd4;
    assign boff = {{14{imm16[15]}}, imm16, 2'b00};
    assign jmp  = {p4[31:28], target26, 2'b00};

    always_comb begin
        npc = p4;
        case (npc_op)
            4'd1:       if (zero)  npc = p4 + boff;
            4'd2:       if (!zero) npc = p4 + boff;
            4'd3, 4'd4: npc = jmp;
            4'd5:       npc = jr_addr;
            default:    npc = p4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            merr_q  <= 1'b0;
            berr_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            merr_q  <= merr_d;
            berr_q  <= berr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        req_d   = req_q;
        valid_d = valid_q;
        merr_d  = merr_q;
        berr_d  = berr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                cnt_d   = '0;
            end
            FETCH: begin
                // An ack on the final allowed cycle still wins over timeout.
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = HOLD;
                end else if (cnt_q == LIM) begin
                    berr_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (advance) begin
                    valid_d = 1'b0;
                    if (npc[1:0] != 2'b00) begin
                        merr_d  = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = npc;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr          = instr_q;
    assign op             = instr_q[31:26];
    assign func           = instr_q[5:0];
    assign instr_valid    = valid_q;
    assign pc             = pc_q;
    assign pc_plus4       = p4;
    assign misalign_err   = merr_q;
    assign bus_err        = berr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios plus random
// next-PC traffic checked against a behavioural PC model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  npc_op;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] jr_addr;
    logic        advance;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  func;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_err;
    logic        bus_err;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC(32'h0000_3000),
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .npc_op      (npc_op),
        .zero        (zero),
        .imm16       (imm16),
        .target26    (target26),
        .jr_addr     (jr_addr),
        .advance     (advance),
        .imem        (bus),
        .instr       (instr),
        .op          (op),
        .func        (func),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .misalign_err(misalign_err),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    int cmp  = 0;
    int errs = 0;
    logic [31:0] m_pc;

    // Next PC straight from the ISA rules, in plain arithmetic.
    function automatic logic [31:0] ref_npc(input logic [31:0] p,
                                            input logic [3:0] o,
                                            input logic z,
                                            input logic [15:0] i,
                                            input logic [25:0] t,
                                            input logic [31:0] j);
        logic [31:0] p4;
        int off;
        p4  = p + 32'd4;
        off = int'($signed(i)) * 4;
        if ((o == 4'd1 && z) || (o == 4'd2 && !z)) return p4 + 32'(off);
        if (o == 4'd3 || o == 4'd4) return (p4 & 32'hF000_0000) | (32'(t) << 2);
        if (o == 4'd5) return j;
        return p4;
    endfunction

    task automatic quiet;
        advance        = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        npc_op         = 4'd0;
        zero           = 1'b0;
        imm16          = 16'h0;
        target26       = 26'h0;
        jr_addr        = 32'h0;
    endtask

    task automatic do_reset;
        quiet();
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        m_pc = 32'h0000_3000;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_fetch(input int d, input logic [31:0] w, output bit ok);
        wait_req(ok);
        if (!ok) return;
        repeat (d) @(negedge clk);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = w;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = ~w;
    endtask

    task automatic do_adv(input logic [3:0] o, input logic z,
                          input logic [15:0] i, input logic [25:0] t,
                          input logic [31:0] j);
        npc_op   = o;
        zero     = z;
        imm16    = i;
        target26 = t;
        jr_addr  = j;
        advance  = 1'b1;
        @(negedge clk);
        advance  = 1'b0;
    endtask

    task automatic test_reset;
        quiet();
        rst = 1'b1;
        bus.imem_ack = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.imem_ack = 1'b0;
        cmp++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
        cmp++; if (pc !== 32'h3000) begin errs++; $display("FAIL reset_pc got %h want 00003000", pc); end
        cmp++; if (bus.imem_addr !== 32'h3000) begin errs++; $display("FAIL reset_addr got %h want 00003000", bus.imem_addr); end
        cmp++; if (instr !== 32'h0) begin errs++; $display("FAIL reset_instr got %h want 0", instr); end
        cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        cmp++; if (misalign_err !== 1'b0 || bus_err !== 1'b0) begin errs++; $display("FAIL reset_errs got %b%b want 00", misalign_err, bus_err); end
        cmp++; if (pc_plus4 !== 32'h3004) begin errs++; $display("FAIL reset_pc4 got %h want 00003004", pc_plus4); end
    endtask

    task automatic test_fetch_latency;
        do_reset();
        cmp++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL lat_idle_req got %b want 0", bus.imem_req); end
        @(negedge clk);
        cmp++; if (bus.imem_req !== 1'b1) begin errs++; $display("FAIL lat_req got %b want 1", bus.imem_req); end
        cmp++; if (bus.imem_addr !== 32'h3000) begin errs++; $display("FAIL lat_addr got %h want 00003000", bus.imem_addr); end
        cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL lat_early_valid got %b want 0", instr_valid); end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h2002_0005;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hFFFF_FFFF;
        cmp++; if (instr_valid !== 1'b1) begin errs++; $display("FAIL lat_valid got %b want 1", instr_valid); end
        cmp++; if (instr !== 32'h2002_0005) begin errs++; $display("FAIL lat_instr got %h want 20020005", instr); end
        cmp++; if (op !== 6'h08 || func !== 6'h05) begin errs++; $display("FAIL lat_opfunc got %h/%h want 08/05", op, func); end
        cmp++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL lat_req_drop got %b want 0", bus.imem_req); end
        do_adv(4'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        m_pc = 32'h3004;
        cmp++; if (pc !== 32'h3004) begin errs++; $display("FAIL adv_pc got %h want 00003004", pc); end
        cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3004) begin errs++; $display("FAIL adv_req got %b/%h want 1/00003004", bus.imem_req, bus.imem_addr); end
        cmp++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL adv_valid got %b want 0", instr_valid); end
    endtask

    task automatic test_branches;
        logic [3:0]  to [7] = '{4'd1, 4'd0, 4'd1, 4'd2, 4'd2, 4'd1, 4'd4};
        logic        tz [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ti [7] = '{16'hFFFE, 16'h0, 16'hFFFE, 16'hFFFE, 16'h0003, 16'hFFFE, 16'h0};
        logic [25:0] tt [7] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0000C40};
        logic [31:0] te [7] = '{32'h3000, 32'h3004, 32'h3008, 32'h3004, 32'h3014, 32'h3010, 32'h3100};
        bit ok;
        logic [31:0] w;
        for (int k = 0; k < 7; k++) begin
            w = $urandom;
            do_fetch(0, w, ok);
            cmp++; if (!ok) begin errs++; $display("FAIL br%0d_req_timeout got none want imem_req", k); end
            cmp++; if (instr !== w || instr_valid !== 1'b1) begin errs++; $display("FAIL br%0d_instr got %h/%b want %h/1", k, instr, instr_valid, w); end
            cmp++; if (pc_plus4 !== m_pc + 32'd4) begin errs++; $display("FAIL br%0d_pc4 got %h want %h", k, pc_plus4, m_pc + 32'd4); end
            do_adv(to[k], tz[k], ti[k], tt[k], 32'h0);
            m_pc = te[k];
            cmp++; if (pc !== te[k]) begin errs++; $display("FAIL br%0d_pc got %h want %h", k, pc, te[k]); end
        end
    endtask

    task automatic test_misalign;
        bit ok;
        logic [31:0] w;
        w = 32'h8C43_0010;
        do_fetch(1, w, ok);
        cmp++; if (!ok || instr !== w) begin errs++; $display("FAIL mis_fetch got %h want %h", instr, w); end
        do_adv(4'd5, 1'b0, 16'h0, 26'h0, 32'h0000_3022);
        cmp++; if (misalign_err !== 1'b1) begin errs++; $display("FAIL mis_flag got %b want 1", misalign_err); end
        cmp++; if (pc !== 32'h3100) begin errs++; $display("FAIL mis_pc got %h want 00003100", pc); end
        cmp++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin errs++; $display("FAIL mis_halt got req %b valid %b want 0 0", bus.imem_req, instr_valid); end
        for (int c = 0; c < 12; c++) begin
            bus.imem_ack   = 1'($urandom);
            bus.imem_rdata = $urandom;
            advance        = 1'($urandom);
            npc_op         = 4'($urandom);
            @(negedge clk);
            cmp++; if (bus.imem_req !== 1'b0 || pc !== 32'h3100 || instr !== w || instr_valid !== 1'b0) begin
                errs++; $display("FAIL halt_frozen%0d got req %b pc %h instr %h valid %b want 0 00003100 %h 0", c, bus.imem_req, pc, instr, instr_valid, w);
            end
            cmp++; if (misalign_err !== 1'b1 || bus_err !== 1'b0) begin errs++; $display("FAIL halt_flags%0d got %b%b want 10", c, misalign_err, bus_err); end
        end
        do_reset();
        cmp++; if (misalign_err !== 1'b0 || pc !== 32'h3000) begin errs++; $display("FAIL mis_clear got %b/%h want 0/00003000", misalign_err, pc); end
    endtask

    task automatic test_timeout;
        bit ok;
        do_reset();
        wait_req(ok);
        cmp++; if (!ok) begin errs++; $display("FAIL to_req got none want imem_req"); end
        repeat (15) @(negedge clk);
        cmp++; if (bus.imem_req !== 1'b1 || bus_err !== 1'b0) begin errs++; $display("FAIL to_cycle16 got req %b err %b want 1 0", bus.imem_req, bus_err); end
        @(negedge clk);
        cmp++; if (bus.imem_req !== 1'b0 || bus_err !== 1'b1) begin errs++; $display("FAIL to_expire got req %b err %b want 0 1", bus.imem_req, bus_err); end
        bus.imem_ack = 1'b1;
        repeat (4) @(negedge clk);
        bus.imem_ack = 1'b0;
        cmp++; if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0 || bus_err !== 1'b1) begin errs++; $display("FAIL to_halt got req %b valid %b err %b want 0 0 1", bus.imem_req, instr_valid, bus_err); end
    endtask

    task automatic test_timeout_edge;
        bit ok;
        logic [31:0] w;
        w = 32'h0123_4567;
        do_reset();
        do_fetch(15, w, ok);
        cmp++; if (!ok) begin errs++; $display("FAIL edge_req got none want imem_req"); end
        cmp++; if (instr_valid !== 1'b1 || instr !== w) begin errs++; $display("FAIL edge_accept got %b/%h want 1/%h", instr_valid, instr, w); end
        cmp++; if (bus_err !== 1'b0) begin errs++; $display("FAIL edge_buserr got %b want 0", bus_err); end
    endtask

    task automatic test_random;
        bit ok;
        logic [31:0] w, e;
        logic [3:0]  o;
        logic        z;
        logic [15:0] i;
        logic [25:0] t;
        logic [31:0] j;
        int d;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            wait_req(ok);
            cmp++; if (!ok) begin errs++; $display("FAIL rnd%0d_req got none want imem_req", n); end
            d = $urandom_range(0, 15);
            for (int c = 0; c < d; c++) begin
                advance = 1'($urandom);
                npc_op  = 4'($urandom);
                jr_addr = $urandom;
                @(negedge clk);
                cmp++; if (pc !== m_pc || bus.imem_req !== 1'b1) begin errs++; $display("FAIL rnd%0d_wait got pc %h req %b want %h 1", n, pc, bus.imem_req, m_pc); end
            end
            advance = 1'b0;
            w = $urandom;
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = w;
            @(negedge clk);
            bus.imem_ack = 1'b0;
            cmp++; if (instr !== w || op !== w[31:26] || func !== w[5:0] || instr_valid !== 1'b1) begin
                errs++; $display("FAIL rnd%0d_instr got %h %h %h %b want %h", n, instr, op, func, instr_valid, w);
            end
            cmp++; if (pc_plus4 !== m_pc + 32'd4) begin errs++; $display("FAIL rnd%0d_pc4 got %h want %h", n, pc_plus4, m_pc + 32'd4); end
            o = 4'($urandom);
            z = 1'($urandom);
            i = 16'($urandom);
            t = 26'($urandom);
            j = $urandom & 32'hFFFF_FFFC;
            e = ref_npc(m_pc, o, z, i, t, j);
            do_adv(o, z, i, t, j);
            m_pc = e;
            cmp++; if (pc !== e || bus.imem_addr !== e || bus.imem_req !== 1'b1) begin
                errs++; $display("FAIL rnd%0d_npc op %0d got %h req %b want %h 1", n, o, pc, bus.imem_req, e);
            end
        end
    endtask

    task automatic test_rst_midfetch;
        bit ok;
        logic [31:0] w;
        do_reset();
        do_fetch(0, 32'h1111_2222, ok);
        do_adv(4'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp++; if (bus.imem_req !== 1'b0 || pc !== 32'h3000 || instr_valid !== 1'b0) begin
            errs++; $display("FAIL midrst got req %b pc %h valid %b want 0 00003000 0", bus.imem_req, pc, instr_valid);
        end
        @(negedge clk);
        cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin errs++; $display("FAIL midrst_restart got %b/%h want 1/00003000", bus.imem_req, bus.imem_addr); end
        w = 32'hAC22_0004;
        do_fetch(0, w, ok);
        cmp++; if (!ok || instr !== w) begin errs++; $display("FAIL midrst_fetch got %h want %h", instr, w); end
    endtask

    task automatic test_stray_ack;
        logic [31:0] w;
        w = instr;
        for (int c = 0; c < 3; c++) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = ~w ^ 32'(c);
            @(negedge clk);
            cmp++; if (instr !== 32'hAC22_0004 || instr_valid !== 1'b1 || pc !== 32'h3000) begin
                errs++; $display("FAIL stray%0d got %h/%b/%h want ac220004/1/00003000", c, instr, instr_valid, pc);
            end
        end
        bus.imem_ack = 1'b0;
        cmp++; if (bus.imem_req !== 1'b0) begin errs++; $display("FAIL stray_req got %b want 0", bus.imem_req); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_fetch_latency();
        test_branches();
        test_misalign();
        test_timeout();
        test_timeout_edge();
        test_random();
        test_rst_midfetch();
        test_stray_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
